// File: rtl/ym2413_write_sequencer_if.sv
// Producer-side and CPU-bus-side signals of the YM2413 write sequencer.
// The sequencer is the bus initiator, so it takes the master view; a producer
// or testbench driving pushes and watching the bus takes the slave view.
interface ym2413_write_sequencer_if #(
   parameter int FIFO_AW = 3
);
   logic               push;
   logic [7:0]         push_reg;
   logic [7:0]         push_dat;
   logic               full;
   logic [FIFO_AW:0]   fifo_count;
   logic               busy;
   logic               overflow;
   logic [14:0]        cpu_a;
   logic [7:0]         cpu_d;
   logic               cpu_ce_n;
   logic               cpu_rw;

   modport master (
      input  push, push_reg, push_dat,
      output full, fifo_count, busy, overflow,
      output cpu_a, cpu_d, cpu_ce_n, cpu_rw
   );

   modport slave (
      output push, push_reg, push_dat,
      input  full, fifo_count, busy, overflow,
      input  cpu_a, cpu_d, cpu_ce_n, cpu_rw
   );
endinterface

// File: rtl/ym2413_write_sequencer.sv
// YM2413 write sequencer: queues (register, data) pairs and replays each one
// as an address write to $9010 followed by a data write to $9030, inserting
// the chip's mandatory post-address and post-data wait times.
module ym2413_write_sequencer #(
   parameter int FIFO_AW    = 3,
   parameter int STROBE_CYC = 2,
   parameter int ADDR_WAIT  = 12,
   parameter int DATA_WAIT  = 84
) (
   input logic                      clk,
   input logic                      reset,
   ym2413_write_sequencer_if.master bus
);

   localparam int DEPTH   = 1 << FIFO_AW;
   localparam int MAX_CYC = (STROBE_CYC > ADDR_WAIT)
                            ? ((STROBE_CYC > DATA_WAIT) ? STROBE_CYC : DATA_WAIT)
                            : ((ADDR_WAIT  > DATA_WAIT) ? ADDR_WAIT  : DATA_WAIT);
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [FIFO_AW:0] FULL_COUNT  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [14:0]      ADDR_PORT   = 15'h1010;
   localparam logic [14:0]      DATA_PORT   = 15'h1030;
   localparam logic [CW-1:0]    STROBE_LOAD = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0]    AWAIT_LOAD  = CW'(ADDR_WAIT - 1);
   localparam logic [CW-1:0]    DWAIT_LOAD  = CW'(DATA_WAIT - 1);

   typedef enum logic [2:0] {IDLE, ASTB, AWAIT, DSTB, DWAIT} state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [7:0]           work_reg;
   logic [7:0]           work_dat;
   logic [15:0]          mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr;
   logic [FIFO_AW-1:0]   rd_ptr;
   logic [FIFO_AW:0]     count_next;
   logic                 push_ok;
   logic                 pop;
   logic                 timer_done;

   // Push acceptance, pop decision and next occupancy.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can leave it unassigned (which would infer a latch).
      count_next = bus.fifo_count;
      timer_done = (cnt == '0);
      push_ok    = bus.push && !bus.full && !reset;
      pop        = (bus.fifo_count != '0) &&
                   ((state == IDLE) || ((state == DWAIT) && timer_done));
      if (push_ok && !pop)
         count_next = bus.fifo_count + 1'b1;
      else if (!push_ok && pop)
         count_next = bus.fifo_count - 1'b1;
   end

   // FIFO storage; contents are discarded on reset by clearing the pointers.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; only pointers and occupancy are cleared, which is what makes old entries invisible.
      if (push_ok)
         mem[wr_ptr] <= {bus.push_reg, bus.push_dat};
   end

   // FIFO pointers, occupancy, full and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         bus.fifo_count <= '0;
         bus.full       <= 1'b0;
         bus.overflow   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         bus.fifo_count <= count_next;
         bus.full       <= (count_next == FULL_COUNT);
         if (bus.push && bus.full)
            bus.overflow <= 1'b1;
      end
   end

   // Write FSM with one shared down-counter; bus outputs and busy are
   // registered from the state held before each edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         work_reg     <= '0;
         work_dat     <= '0;
         bus.cpu_a    <= '0;
         bus.cpu_d    <= '0;
         bus.cpu_ce_n <= 1'b1;
         bus.cpu_rw   <= 1'b1;
         bus.busy     <= 1'b0;
      end else begin
         bus.busy     <= (state != IDLE) || (bus.fifo_count != '0);
         bus.cpu_a    <= '0;
         bus.cpu_d    <= '0;
         bus.cpu_ce_n <= 1'b1;
         bus.cpu_rw   <= 1'b1;
         if (state == ASTB) begin
            bus.cpu_a    <= ADDR_PORT;
            bus.cpu_d    <= work_reg;
            bus.cpu_ce_n <= 1'b0;
            bus.cpu_rw   <= 1'b0;
         end else if (state == DSTB) begin
            bus.cpu_a    <= DATA_PORT;
            bus.cpu_d    <= work_dat;
            bus.cpu_ce_n <= 1'b0;
            bus.cpu_rw   <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (pop) begin
                  {work_reg, work_dat} <= mem[rd_ptr];
                  cnt                  <= STROBE_LOAD;
                  state                <= ASTB;
               end
            end
            ASTB: begin
               if (timer_done) begin
                  cnt   <= AWAIT_LOAD;
                  state <= AWAIT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            AWAIT: begin
               if (timer_done) begin
                  cnt   <= STROBE_LOAD;
                  state <= DSTB;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DSTB: begin
               if (timer_done) begin
                  cnt   <= DWAIT_LOAD;
                  state <= DWAIT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DWAIT: begin
               if (!timer_done) begin
                  cnt <= cnt - 1'b1;
               end else if (pop) begin
                  {work_reg, work_dat} <= mem[rd_ptr];
                  cnt                  <= STROBE_LOAD;
                  state                <= ASTB;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ym2413_write_sequencer.sv
// Self-checking bench for ym2413_write_sequencer. Instance A uses the default
// timing and is compared every cycle against a schedule-based reference
// model; instance B uses the minimum timing (1/1/1) for the boundary case.
module tb_ym2413_write_sequencer;

   localparam int DEPTH = 8;
   localparam int S     = 2;
   localparam int AWT   = 12;
   localparam int DWT   = 84;
   localparam int PER   = S + AWT + S + DWT;

   logic clk = 1'b0;
   logic reset_a;
   logic reset_b;

   always #5 clk = ~clk;

   ym2413_write_sequencer_if #(.FIFO_AW(3)) bus_a ();
   ym2413_write_sequencer_if #(.FIFO_AW(3)) bus_b ();

   ym2413_write_sequencer #(
      .FIFO_AW(3), .STROBE_CYC(S), .ADDR_WAIT(AWT), .DATA_WAIT(DWT)
   ) dut_a (
      .clk  (clk),
      .reset(reset_a),
      .bus  (bus_a)
   );

   ym2413_write_sequencer #(
      .FIFO_AW(3), .STROBE_CYC(1), .ADDR_WAIT(1), .DATA_WAIT(1)
   ) dut_b (
      .clk  (clk),
      .reset(reset_b),
      .bus  (bus_b)
   );

   // ---------------- bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // ---------------- reference model for instance A ----------------
   // Each accepted pair is queued; a pop may happen once the previous pop is
   // a full write period old. A pop at edge p schedules the address strobe
   // for the cycles after edges p+1..p+S and the data strobe S+AWT later.
   typedef struct {
      int          first;
      int          last;
      logic [14:0] a;
      logic [7:0]  d;
   } win_t;

   win_t        wins[$];
   logic [15:0] mq[$];
   int          next_pop = 0;
   bit          m_ovf    = 1'b0;
   bit          m_busy   = 1'b0;

   // ---------------- bus log for instance A ----------------
   int          a_start[$];
   logic [7:0]  a_reg[$];
   logic [7:0]  d_dat[$];
   logic        prev_ce = 1'b1;

   typedef struct {
      int          off;
      logic        ce_n;
      logic [14:0] a;
      logic [7:0]  d;
      logic        busy;
   } vec_t;

   vec_t single_tab[10];
   vec_t bnd_tab[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      int          pre_count;
      bit          pre_active;
      bit          do_pop;
      bit          accept;
      logic [15:0] ent;
      cyc++;
      if (reset_a) begin
         mq.delete();
         wins.delete();
         next_pop = 0;
         m_ovf    = 1'b0;
         m_busy   = 1'b0;
      end else begin
         pre_count  = mq.size();
         pre_active = (cyc - 1) < next_pop;
         m_busy     = pre_active || (pre_count != 0);
         do_pop     = (pre_count > 0) && (cyc >= next_pop);
         accept     = bus_a.push && (pre_count < DEPTH);
         if (bus_a.push && !accept)
            m_ovf = 1'b1;
         if (do_pop) begin
            ent = mq.pop_front();
            wins.push_back('{cyc + 1, cyc + S, 15'h1010, ent[15:8]});
            wins.push_back('{cyc + 1 + S + AWT, cyc + 2 * S + AWT, 15'h1030, ent[7:0]});
            next_pop = cyc + PER;
         end
         if (accept)
            mq.push_back({bus_a.push_reg, bus_a.push_dat});
      end
      while (wins.size() > 0 && wins[0].last < cyc)
         wins.delete(0);
   endtask

   task automatic compare_a();
      logic        exp_ce;
      logic [14:0] ea;
      logic [7:0]  ed;
      exp_ce = 1'b1;
      ea     = '0;
      ed     = '0;
      foreach (wins[i]) begin
         if (wins[i].first <= cyc && cyc <= wins[i].last) begin
            exp_ce = 1'b0;
            ea     = wins[i].a;
            ed     = wins[i].d;
         end
      end
      check("cpu_ce_n",   32'(bus_a.cpu_ce_n),   32'(exp_ce));
      check("cpu_rw",     32'(bus_a.cpu_rw),     32'(exp_ce));
      check("cpu_a",      32'(bus_a.cpu_a),      32'(ea));
      check("cpu_d",      32'(bus_a.cpu_d),      32'(ed));
      check("fifo_count", 32'(bus_a.fifo_count), 32'(mq.size()));
      check("full",       32'(bus_a.full),       32'(mq.size() == DEPTH));
      check("busy",       32'(bus_a.busy),       32'(m_busy));
      check("overflow",   32'(bus_a.overflow),   32'(m_ovf));
   endtask

   task automatic log_a();
      if (bus_a.cpu_ce_n == 1'b0 && prev_ce == 1'b1) begin
         if (bus_a.cpu_a == 15'h1010) begin
            a_start.push_back(cyc);
            a_reg.push_back(bus_a.cpu_d);
         end else if (bus_a.cpu_a == 15'h1030) begin
            d_dat.push_back(bus_a.cpu_d);
         end
      end
      prev_ce = bus_a.cpu_ce_n;
   endtask

   // One clock: inputs set before the call are sampled at the edge; outputs
   // are compared 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      compare_a();
      log_a();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++)
         tick();
   endtask

   task automatic drive_a(input logic p, input logic [7:0] r, input logic [7:0] d);
      bus_a.push     = p;
      bus_a.push_reg = r;
      bus_a.push_dat = d;
   endtask

   task automatic check_vec(input string tag, input vec_t v, input logic ce,
                            input logic [14:0] a, input logic [7:0] d, input logic busy);
      check($sformatf("%s_k%0d_ce_n", tag, v.off), 32'(ce),   32'(v.ce_n));
      check($sformatf("%s_k%0d_a",    tag, v.off), 32'(a),    32'(v.a));
      check($sformatf("%s_k%0d_d",    tag, v.off), 32'(d),    32'(v.d));
      check($sformatf("%s_k%0d_busy", tag, v.off), 32'(busy), 32'(v.busy));
   endtask

   initial begin
      int          k;
      int          base_s;
      int          base_d;
      int          sent;
      logic [15:0] exp_pairs[$];

      // Single write (0x10, 0x5A) from idle; offsets count edges after the push edge.
      single_tab[0] = '{1,   1'b1, 15'h0000, 8'h00, 1'b1};
      single_tab[1] = '{2,   1'b0, 15'h1010, 8'h10, 1'b1};
      single_tab[2] = '{3,   1'b0, 15'h1010, 8'h10, 1'b1};
      single_tab[3] = '{4,   1'b1, 15'h0000, 8'h00, 1'b1};
      single_tab[4] = '{15,  1'b1, 15'h0000, 8'h00, 1'b1};
      single_tab[5] = '{16,  1'b0, 15'h1030, 8'h5A, 1'b1};
      single_tab[6] = '{17,  1'b0, 15'h1030, 8'h5A, 1'b1};
      single_tab[7] = '{18,  1'b1, 15'h0000, 8'h00, 1'b1};
      single_tab[8] = '{101, 1'b1, 15'h0000, 8'h00, 1'b1};
      single_tab[9] = '{102, 1'b1, 15'h0000, 8'h00, 1'b0};

      // Minimum timing: pairs (21,33) and (22,44) pushed on consecutive edges.
      bnd_tab[0] = '{1,  1'b1, 15'h0000, 8'h00, 1'b1};
      bnd_tab[1] = '{2,  1'b0, 15'h1010, 8'h21, 1'b1};
      bnd_tab[2] = '{3,  1'b1, 15'h0000, 8'h00, 1'b1};
      bnd_tab[3] = '{4,  1'b0, 15'h1030, 8'h33, 1'b1};
      bnd_tab[4] = '{5,  1'b1, 15'h0000, 8'h00, 1'b1};
      bnd_tab[5] = '{6,  1'b0, 15'h1010, 8'h22, 1'b1};
      bnd_tab[6] = '{7,  1'b1, 15'h0000, 8'h00, 1'b1};
      bnd_tab[7] = '{8,  1'b0, 15'h1030, 8'h44, 1'b1};
      bnd_tab[8] = '{9,  1'b1, 15'h0000, 8'h00, 1'b1};
      bnd_tab[9] = '{10, 1'b1, 15'h0000, 8'h00, 1'b0};

      reset_a = 1'b1;
      reset_b = 1'b1;
      drive_a(1'b1, 8'hEE, 8'hEE);   // ignored while reset is high
      bus_b.push     = 1'b0;
      bus_b.push_reg = '0;
      bus_b.push_dat = '0;
      ticks(3);
      drive_a(1'b0, 8'h00, 8'h00);
      reset_a = 1'b0;
      reset_b = 1'b0;
      ticks(2);

      // ---- boundary timing on instance B ----
      bus_b.push     = 1'b1;
      bus_b.push_reg = 8'h21;
      bus_b.push_dat = 8'h33;
      tick();
      bus_b.push_reg = 8'h22;
      bus_b.push_dat = 8'h44;
      tick();
      bus_b.push = 1'b0;
      k = 1;
      for (int j = 0; j < 10; j++) begin
         while (k < bnd_tab[j].off) begin
            tick();
            k++;
         end
         check_vec("bnd", bnd_tab[j], bus_b.cpu_ce_n, bus_b.cpu_a, bus_b.cpu_d, bus_b.busy);
         check($sformatf("bnd_k%0d_rw", bnd_tab[j].off), 32'(bus_b.cpu_rw), 32'(bnd_tab[j].ce_n));
      end

      // ---- single write on instance A ----
      drive_a(1'b1, 8'h10, 8'h5A);
      tick();
      drive_a(1'b0, 8'h00, 8'h00);
      k = 0;
      for (int j = 0; j < 10; j++) begin
         while (k < single_tab[j].off) begin
            tick();
            k++;
         end
         check_vec("single", single_tab[j], bus_a.cpu_ce_n, bus_a.cpu_a, bus_a.cpu_d, bus_a.busy);
      end
      ticks(5);

      // ---- back-to-back: three pairs on consecutive edges ----
      base_s = a_start.size();
      base_d = d_dat.size();
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b1, 8'h20 + 8'(i), 8'hA0 + 8'(i));
         tick();
      end
      drive_a(1'b0, 8'h00, 8'h00);
      ticks(320);
      check("b2b_addr_strobes", 32'(a_start.size() - base_s), 32'd3);
      check("b2b_data_strobes", 32'(d_dat.size() - base_d), 32'd3);
      if (a_start.size() - base_s == 3 && d_dat.size() - base_d == 3) begin
         check("b2b_gap1", 32'(a_start[base_s + 1] - a_start[base_s]), 32'(PER));
         check("b2b_gap2", 32'(a_start[base_s + 2] - a_start[base_s]), 32'(2 * PER));
         for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_reg%0d", i), 32'(a_reg[base_s + i]), 32'(8'h20 + 8'(i)));
            check($sformatf("b2b_dat%0d", i), 32'(d_dat[base_d + i]), 32'(8'hA0 + 8'(i)));
         end
      end

      // ---- overflow: ten consecutive pushes from idle ----
      base_s = a_start.size();
      base_d = d_dat.size();
      for (int i = 0; i < 10; i++) begin
         drive_a(1'b1, 8'h30 + 8'(i), 8'hB0 + 8'(i));
         tick();
         if (i == 8)
            check("ovf_full_after_9th", 32'(bus_a.full), 32'd1);
      end
      drive_a(1'b0, 8'h00, 8'h00);
      check("ovf_flag", 32'(bus_a.overflow), 32'd1);
      check("ovf_count", 32'(bus_a.fifo_count), 32'd8);
      ticks(9 * PER + 20);
      check("ovf_addr_strobes", 32'(a_start.size() - base_s), 32'd9);
      check("ovf_data_strobes", 32'(d_dat.size() - base_d), 32'd9);
      if (a_start.size() - base_s == 9 && d_dat.size() - base_d == 9) begin
         check("ovf_last_reg", 32'(a_reg[base_s + 8]), 32'h38);
         check("ovf_last_dat", 32'(d_dat[base_d + 8]), 32'hB8);
      end

      // ---- reset during the 5th AWAIT cycle with 3 entries queued ----
      base_d = d_dat.size();
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, 8'h40 + 8'(i), 8'hC0 + 8'(i));
         tick();
      end
      drive_a(1'b0, 8'h00, 8'h00);
      ticks(4);
      check("rst_queued_before", 32'(bus_a.fifo_count), 32'd3);
      reset_a = 1'b1;
      tick();
      reset_a = 1'b0;
      check("rst_ce_n", 32'(bus_a.cpu_ce_n), 32'd1);
      check("rst_count", 32'(bus_a.fifo_count), 32'd0);
      check("rst_busy", 32'(bus_a.busy), 32'd0);
      check("rst_overflow", 32'(bus_a.overflow), 32'd0);
      ticks(150);
      check("rst_no_data_strobe", 32'(d_dat.size() - base_d), 32'd0);

      // ---- wrap-around: 20 pairs streamed with a shallow queue ----
      base_s = a_start.size();
      base_d = d_dat.size();
      sent   = 0;
      for (int t = 0; t < 3000 && sent < 20; t++) begin
         if (mq.size() < 4) begin
            drive_a(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            exp_pairs.push_back({bus_a.push_reg, bus_a.push_dat});
            sent++;
         end else begin
            drive_a(1'b0, 8'h00, 8'h00);
         end
         tick();
      end
      drive_a(1'b0, 8'h00, 8'h00);
      ticks(6 * PER);
      check("wrap_sent", 32'(sent), 32'd20);
      check("wrap_addr_strobes", 32'(a_start.size() - base_s), 32'd20);
      check("wrap_data_strobes", 32'(d_dat.size() - base_d), 32'd20);
      for (int i = 0; i < 20; i++) begin
         if (base_s + i < a_start.size() && base_d + i < d_dat.size() && i < exp_pairs.size()) begin
            check($sformatf("wrap_reg%0d", i), 32'(a_reg[base_s + i]), 32'(exp_pairs[i][15:8]));
            check($sformatf("wrap_dat%0d", i), 32'(d_dat[base_d + i]), 32'(exp_pairs[i][7:0]));
         end
      end

      // ---- randomized traffic with one burst that overruns the FIFO ----
      for (int t = 0; t < 3000; t++) begin
         drive_a((t >= 1500 && t < 1512) || ($urandom_range(0, 99) < 2),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         tick();
      end
      drive_a(1'b0, 8'h00, 8'h00);
      ticks(12 * PER);
      check("final_busy", 32'(bus_a.busy), 32'd0);
      check("final_count", 32'(bus_a.fifo_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
